// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared definitions for the ADCxx1S101 burst capture engine
//
// Holds the capture FSM state encoding, the fixed ADC frame geometry and a
// parameter legality check used at elaboration by the top level.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_QUIET,
        ST_HOLD,
        ST_DONE
    } adc_state_t;

    // One conversion frame is 16 SCLK periods; the ADC shifts out three
    // leading zeros before the sample MSB.
    localparam int FRAME_SCLKS = 16;
    localparam int LEAD_ZEROS  = 3;

    function automatic bit params_legal(
        input int adc_bits,
        input int out_width,
        input int sclk_div,
        input int quiet_cycles,
        input int burst_len,
        input int avg_log2
    );
        return (adc_bits == 8 || adc_bits == 10 || adc_bits == 12)
            && (out_width >= 1 && out_width <= 16)
            && (sclk_div >= 1)
            && (quiet_cycles >= 1)
            && (burst_len >= 1 && burst_len <= 255)
            && (avg_log2 >= 0 && avg_log2 <= 3);
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - SCLK divider and rising-edge counter for one ADC frame
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   en           high while the FSM is in FRAME; low parks sclk high
//   sclk         ADC serial clock (idles high, falls first)
//   sample       high in the clk cycle whose closing edge drives sclk rising
//   edge_idx     index (0..15) of the rising edge flagged by sample
//   frame_end    sample of the last rising edge of the frame
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       sclk,
    output logic       sample,
    output logic [3:0] edge_idx,
    output logic       frame_end
);

    localparam int DIV_W = $clog2(SCLK_DIV + 1);

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       edge_cnt;
    logic             sclk_q;
    logic             toggle;

    assign toggle = en && (div_cnt == DIV_W'(SCLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b1;
        end else if (!en) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b1;
        end else if (toggle) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
            // The edge counter advances after each rising edge it has flagged.
            if (!sclk_q) begin
                edge_cnt <= edge_cnt + 4'd1;
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign sclk      = sclk_q;
    assign sample    = toggle && !sclk_q;
    assign edge_idx  = edge_cnt;
    assign frame_end = sample && (edge_cnt == 4'(FRAME_SCLKS - 1));

endmodule

// File: rtl/adcxx1s_burst_capture.sv
// rtl/adcxx1s_burst_capture.sv - burst/averaging capture engine for ADCxx1S101
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   adc_capture_start   one-cycle start pulse, honoured only when idle
//   fifo_full           pixel FIFO full; holds the pending word
//   sdata               ADC serial data
//   adc_capture_done    one-cycle pulse after the last word of a burst
//   busy                capture in progress
//   write_enable        one-cycle FIFO write strobe
//   pixel_data          word presented with write_enable
//   sclk, cs_n          ADC serial clock and chip select
module adcxx1s_burst_capture
    import adc_pkg::*;
#(
    parameter int ADC_BITS     = 8,
    parameter int OUT_WIDTH    = 8,
    parameter int SCLK_DIV     = 2,
    parameter int QUIET_CYCLES = 4,
    parameter int BURST_LEN    = 1,
    parameter int AVG_LOG2     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adc_capture_start,
    input  logic                 fifo_full,
    input  logic                 sdata,
    output logic                 adc_capture_done,
    output logic                 busy,
    output logic                 write_enable,
    output logic [OUT_WIDTH-1:0] pixel_data,
    output logic                 sclk,
    output logic                 cs_n
);

    if (!params_legal(ADC_BITS, OUT_WIDTH, SCLK_DIV, QUIET_CYCLES, BURST_LEN, AVG_LOG2)) begin : g_bad_params
        $error("adcxx1s_burst_capture: illegal parameter combination");
    end

    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int NFR   = 1 << AVG_LOG2;
    localparam int QW    = $clog2(QUIET_CYCLES + 1);
    localparam logic [3:0] SLOT_LO = 4'(LEAD_ZEROS);
    localparam logic [3:0] SLOT_HI = 4'(LEAD_ZEROS + ADC_BITS - 1);

    adc_state_t state, state_nxt;

    logic                 start_q;
    logic [ADC_BITS-1:0]  shreg;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_sum;
    logic [ADC_BITS-1:0]  avg;
    logic [OUT_WIDTH-1:0] word;
    logic [2:0]           frm_cnt;
    logic [7:0]           word_cnt;
    logic [QW-1:0]        q_cnt;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_q;

    logic       sample, frame_end;
    logic [3:0] edge_idx;
    logic       in_slot, word_done, last_word, out_free, quiet_done;

    adc_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (state == ST_FRAME),
        .sclk      (sclk),
        .sample    (sample),
        .edge_idx  (edge_idx),
        .frame_end (frame_end)
    );

    assign in_slot    = (edge_idx >= SLOT_LO) && (edge_idx <= SLOT_HI);
    assign word_done  = frame_end && (frm_cnt == 3'(NFR - 1));
    assign last_word  = (word_cnt == 8'(BURST_LEN - 1));
    assign quiet_done = (q_cnt == QW'(QUIET_CYCLES - 1));

    // fifo_full is used combinationally so a word leaves the cycle it drops.
    assign write_enable = out_valid && !fifo_full;
    // A word leaving this cycle frees the register for the next frame.
    assign out_free     = !out_valid || write_enable;

    // The final sample bit lands before the frame's last rising edge, so the
    // shift register already holds the full sample when frame_end fires.
    assign acc_sum = acc + ACC_W'(shreg);
    assign avg     = ADC_BITS'(acc_sum >> AVG_LOG2);

    if (OUT_WIDTH <= ADC_BITS) begin : g_out_narrow
        assign word = OUT_WIDTH'(avg >> (ADC_BITS - OUT_WIDTH));
    end else begin : g_out_wide
        assign word = OUT_WIDTH'(avg) << (OUT_WIDTH - ADC_BITS);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start_q) state_nxt = ST_FRAME;
            end
            ST_FRAME: begin
                if (frame_end) state_nxt = ST_QUIET;
            end
            ST_QUIET: begin
                if (write_enable && last_word) state_nxt = ST_DONE;
                else if (quiet_done)           state_nxt = out_free ? ST_FRAME : ST_HOLD;
            end
            ST_HOLD: begin
                if (write_enable && last_word) state_nxt = ST_DONE;
                else if (out_free)             state_nxt = ST_FRAME;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cs_n             = 1'b1;
        busy             = 1'b0;
        adc_capture_done = 1'b0;
        unique case (state)
            ST_FRAME: begin
                cs_n = 1'b0;
                busy = 1'b1;
            end
            ST_QUIET, ST_HOLD: busy = 1'b1;
            ST_DONE:           adc_capture_done = 1'b1;
            default: ;
        endcase
    end

    assign pixel_data = out_q;

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q   <= 1'b0;
            shreg     <= '0;
            acc       <= '0;
            frm_cnt   <= '0;
            word_cnt  <= '0;
            q_cnt     <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
        end else begin
            // Registering the start gives the one-cycle gap before cs_n falls;
            // clearing on itself keeps a held start from re-arming.
            start_q <= (state == ST_IDLE) && adc_capture_start && !start_q;

            if (state != ST_QUIET) begin
                q_cnt <= '0;
            end else if (!quiet_done) begin
                q_cnt <= q_cnt + QW'(1);
            end

            if (sample && in_slot) begin
                shreg <= {shreg[ADC_BITS-2:0], sdata};
            end

            if (state == ST_IDLE) begin
                acc     <= '0;
                frm_cnt <= '0;
            end else if (word_done) begin
                acc     <= '0;
                frm_cnt <= '0;
            end else if (frame_end) begin
                acc     <= acc_sum;
                frm_cnt <= frm_cnt + 3'd1;
            end

            if (word_done) begin
                out_q     <= word;
                out_valid <= 1'b1;
            end else if (write_enable) begin
                out_valid <= 1'b0;
            end

            if (state == ST_IDLE) begin
                word_cnt <= '0;
            end else if (write_enable) begin
                word_cnt <= word_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adcxx1s_burst_capture.sv
// tb/tb_adcxx1s_burst_capture.sv - directed bench for adcxx1s_burst_capture
module tb_adcxx1s_burst_capture;

    localparam int NDUT = 5;
    // 0 baseline, 1 burst of 4, 2 averaging x4, 3 12->8 bit, 4 12->16 bit
    localparam int ADCB [NDUT] = '{8, 8, 8, 12, 12};
    localparam int OUTW [NDUT] = '{8, 8, 8, 8, 16};
    localparam int BRST [NDUT] = '{1, 4, 1, 1, 1};
    localparam int AVGL [NDUT] = '{0, 0, 2, 0, 0};

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic fifo_full = 1'b0;
    logic [NDUT-1:0] start = '0;

    wire [NDUT-1:0]       sdata, done, busy, we, sclk, cs_n;
    wire [NDUT-1:0][15:0] pd;

    logic [11:0] samp [NDUT][4];

    int n_checks = 0;
    int n_fail   = 0;

    int          we_cyc[$];
    int          done_cyc[$];
    int          fall_cyc[$];
    logic [15:0] we_dat[$];
    logic        cs_h   [0:399];
    logic        sclk_h [0:399];
    logic        busy_h [0:399];

    always #5 clk = ~clk;

    function automatic logic [15:0] mk_frame(input logic [11:0] s, input int bits);
        logic [15:0] f;
        f = 16'hFFFF;
        for (int i = 0; i < bits; i++) f[12-i] = s[bits-1-i];
        return f;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [OUTW[g]-1:0] pdl;
        logic [15:0] frame = 16'hFFFF;
        int rc = 16;
        int fc = 0;

        adcxx1s_burst_capture #(
            .ADC_BITS     (ADCB[g]),
            .OUT_WIDTH    (OUTW[g]),
            .SCLK_DIV     (2),
            .QUIET_CYCLES (4),
            .BURST_LEN    (BRST[g]),
            .AVG_LOG2     (AVGL[g])
        ) u_dut (
            .clk               (clk),
            .reset             (reset),
            .adc_capture_start (start[g]),
            .fifo_full         (fifo_full),
            .sdata             (sdata[g]),
            .adc_capture_done  (done[g]),
            .busy              (busy[g]),
            .write_enable      (we[g]),
            .pixel_data        (pdl),
            .sclk              (sclk[g]),
            .cs_n              (cs_n[g])
        );

        assign pd[g] = 16'(pdl);

        // ADC model: a new frame per cs_n fall, one bit per SCLK rising edge.
        always @(negedge cs_n[g]) begin
            frame = mk_frame(samp[g][fc % 4], ADCB[g]);
            fc++;
            rc = 0;
        end
        always @(posedge sclk[g]) if (!cs_n[g] && rc < 16) rc++;
        assign sdata[g] = (rc < 16) ? frame[15-rc] : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [15:0] atd(input logic [15:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 16'hDEAD;
    endfunction

    // Pulses start on DUT g (edge N) and observes n cycles; index c in the
    // records means "after edge N+c". fifo_full is high for cycles
    // [ff_on, ff_off); a second start is driven during cycle restart_at.
    task automatic run(input int g, input int n, input int ff_on, input int ff_off, input int restart_at);
        logic prev_cs;
        we_cyc.delete();
        we_dat.delete();
        done_cyc.delete();
        fall_cyc.delete();
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        #1;
        cs_h[0]   = cs_n[g];
        sclk_h[0] = sclk[g];
        busy_h[0] = busy[g];
        prev_cs   = cs_n[g];
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            fifo_full = (c >= ff_on) && (c < ff_off);
            start[g]  = (c == restart_at);
            #1;
            cs_h[c]   = cs_n[g];
            sclk_h[c] = sclk[g];
            busy_h[c] = busy[g];
            if (we[g]) begin
                we_cyc.push_back(c);
                we_dat.push_back(pd[g]);
            end
            if (done[g]) done_cyc.push_back(c);
            if (prev_cs && !cs_n[g]) fall_cyc.push_back(c);
            prev_cs = cs_n[g];
        end
        start[g]  = 1'b0;
        fifo_full = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            samp[0][i] = 12'h0A5;
            samp[3][i] = 12'hABC;
            samp[4][i] = 12'hABC;
        end
        samp[1][0] = 12'h012; samp[1][1] = 12'h034; samp[1][2] = 12'h056; samp[1][3] = 12'h078;
        samp[2][0] = 12'd10;  samp[2][1] = 12'd11;  samp[2][2] = 12'd12;  samp[2][3] = 12'd13;

        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n",  32'(cs_n[0]), 32'd1);
        check("rst_sclk",  32'(sclk[0]), 32'd1);
        check("rst_we",    32'(we[0]),   32'd0);
        check("rst_done",  32'(done[0]), 32'd0);
        check("rst_busy",  32'(busy[0]), 32'd0);
        check("rst_pdata", 32'(pd[0]),   32'd0);
        reset = 1'b0;

        // Baseline, with a start during the DONE cycle that must be ignored.
        run(0, 80, 0, 0, 66);
        check("base_cs_n_at_N",    32'(cs_h[0]),   32'd1);
        check("base_busy_at_N",    32'(busy_h[0]), 32'd0);
        check("base_cs_n_at_N1",   32'(cs_h[1]),   32'd0);
        check("base_busy_at_N1",   32'(busy_h[1]), 32'd1);
        check("base_sclk_at_N2",   32'(sclk_h[2]), 32'd1);
        check("base_sclk_at_N3",   32'(sclk_h[3]), 32'd0);
        check("base_cs_n_at_N64",  32'(cs_h[64]),  32'd0);
        check("base_cs_n_at_N65",  32'(cs_h[65]),  32'd1);
        check("base_we_count",     32'(we_cyc.size()), 32'd1);
        check("base_we_cycle",     32'(at(we_cyc, 0)), 32'd65);
        check("base_pdata",        32'(atd(we_dat, 0)), 32'h0A5);
        check("base_done_count",   32'(done_cyc.size()), 32'd1);
        check("base_done_cycle",   32'(at(done_cyc, 0)), 32'd66);
        check("base_busy_at_done", 32'(busy_h[66]), 32'd0);
        check("base_restart_ign",  32'(fall_cyc.size()), 32'd1);
        check("base_busy_after",   32'(busy_h[70]), 32'd0);

        // Reset in the middle of a frame.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("midrst_pre_cs_n", 32'(cs_n[0]), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_cs_n",  32'(cs_n[0]), 32'd1);
        check("midrst_sclk",  32'(sclk[0]), 32'd1);
        check("midrst_busy",  32'(busy[0]), 32'd0);
        check("midrst_pdata", 32'(pd[0]),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        run(0, 80, 0, 0, -1);
        check("postrst_we_cycle", 32'(at(we_cyc, 0)), 32'd65);
        check("postrst_pdata",    32'(atd(we_dat, 0)), 32'h0A5);
        check("postrst_done",     32'(at(done_cyc, 0)), 32'd66);

        // Burst of four, unstalled.
        run(1, 300, 0, 0, -1);
        check("burst_falls",      32'(fall_cyc.size()), 32'd4);
        check("burst_fall_space", 32'(at(fall_cyc, 1) - at(fall_cyc, 0)), 32'd68);
        check("burst_fall3",      32'(at(fall_cyc, 3)), 32'd205);
        check("burst_we_count",   32'(we_cyc.size()), 32'd4);
        check("burst_we3_cycle",  32'(at(we_cyc, 3)), 32'd269);
        check("burst_pdata0",     32'(atd(we_dat, 0)), 32'h012);
        check("burst_pdata3",     32'(atd(we_dat, 3)), 32'h078);
        check("burst_done_count", 32'(done_cyc.size()), 32'd1);
        check("burst_done_cycle", 32'(at(done_cyc, 0)), 32'd270);

        // Burst of four with fifo_full over the second write slot.
        run(1, 300, 130, 150, -1);
        check("stall_falls",     32'(fall_cyc.size()), 32'd4);
        check("stall_fall2",     32'(at(fall_cyc, 2)), 32'd151);
        check("stall_we0_cycle", 32'(at(we_cyc, 0)), 32'd65);
        check("stall_we1_cycle", 32'(at(we_cyc, 1)), 32'd150);
        check("stall_pdata1",    32'(atd(we_dat, 1)), 32'h034);
        check("stall_we_count",  32'(we_cyc.size()), 32'd4);
        check("stall_done",      32'(at(done_cyc, 0)), 32'd284);

        // Averaging of four frames: (10+11+12+13)/4 = 11.
        run(2, 300, 0, 0, -1);
        check("avg_falls",    32'(fall_cyc.size()), 32'd4);
        check("avg_we_count", 32'(we_cyc.size()), 32'd1);
        check("avg_we_cycle", 32'(at(we_cyc, 0)), 32'd269);
        check("avg_pdata",    32'(atd(we_dat, 0)), 32'd11);

        // 12-bit converter truncated to 8 bits and left-justified in 16 bits.
        run(3, 80, 0, 0, -1);
        check("w12o8_we_cycle", 32'(at(we_cyc, 0)), 32'd65);
        check("w12o8_pdata",    32'(atd(we_dat, 0)), 32'h0AB);
        run(4, 80, 0, 0, -1);
        check("w12o16_we_cycle", 32'(at(we_cyc, 0)), 32'd65);
        check("w12o16_pdata",    32'(atd(we_dat, 0)), 32'hABC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
